mesi_isc_cpu_agent: RTL and testbench

- Cache-side endpoint for one CPU port of the MESI intersection controller.
- Request side: turns CPU read/write requests into the main-bus broadcast-then-access sequence.
  - Drives mbus_cmd/mbus_addr and consumes mbus_ack.
  - Sequence: broadcast, wait for enable, then the actual access.
- Snoop side: the responder end of the coherence bus.
  - Decodes cbus_cmd and returns cbus_ack with configurable latency.
- Used as a bus-functional endpoint in cluster benches and as the protocol front-end of the cache tile.

---
 rtl/mesi_isc_cpu_agent_if.sv | 33 +++
 rtl/mesi_isc_cpu_agent.sv | 248 ++++++++++++++++++++++++
 tb/tb_mesi_isc_cpu_agent.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_isc_cpu_agent_if.sv
// rtl/mesi_isc_cpu_agent_if.sv - main-bus and coherence-bus bundle for one CPU port
//
// Purpose: carries the controller-facing signals of one MESI ISC CPU port.
// Signals (named from the agent's point of view):
//   mbus_cmd_o   agent -> controller  main-bus command
//   mbus_addr_o  agent -> controller  main-bus address
//   mbus_ack_i   controller -> agent  main-bus acknowledge
//   cbus_addr_i  controller -> agent  coherence-bus address
//   cbus_cmd_i   controller -> agent  coherence-bus command
//   cbus_ack_o   agent -> controller  coherence-bus acknowledge
// Modports: master = agent side, slave = controller side.
interface mesi_isc_cpu_agent_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3
);
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o;
  logic [ADDR_WIDTH-1:0]     mbus_addr_o;
  logic                      mbus_ack_i;
  logic [ADDR_WIDTH-1:0]     cbus_addr_i;
  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
  logic                      cbus_ack_o;

  modport master (
    output mbus_cmd_o, mbus_addr_o, cbus_ack_o,
    input  mbus_ack_i, cbus_addr_i, cbus_cmd_i
  );

  modport slave (
    input  mbus_cmd_o, mbus_addr_o, cbus_ack_o,
    output mbus_ack_i, cbus_addr_i, cbus_cmd_i
  );
endinterface

// File: rtl/mesi_isc_cpu_agent.sv
// rtl/mesi_isc_cpu_agent.sv - MESI ISC CPU-port agent (request sequencer + snoop responder)
//
// Purpose: turns CPU read/write requests into the broadcast / wait-for-enable /
// access sequence on the main bus, and answers coherence-bus commands with a
// configurable latency.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_valid_i     CPU request valid
//   req_wr_i        1 = write, 0 = read
//   req_addr_i      request address
//   req_ready_o     request FSM idle, request will be taken
//   done_o          one-cycle pulse when the access phase is acked
//   bus             mesi_isc_cpu_agent_if.master (mbus_*/cbus_* signals)
//   snoop_cnt_o     saturating count of acked WR_SNOOP/RD_SNOOP
//   err_o           sticky protocol-error flag
// Optional feature macro: MESI_ISC_AGENT_ADDR_CHK_EN
//   defined   -> an EN_* taken in R_WAIT_EN must carry the latched request
//                address on cbus_addr_i, otherwise err_o is set and the
//                request keeps waiting (the EN is still acked).
//   undefined -> cbus_addr_i is ignored.

`ifndef MESI_ISC_DEFINES
`define MESI_ISC_DEFINES
`define MESI_ISC_MBUS_CMD_NOP      0
`define MESI_ISC_MBUS_CMD_WR       1
`define MESI_ISC_MBUS_CMD_RD       2
`define MESI_ISC_MBUS_CMD_WR_BROAD 3
`define MESI_ISC_MBUS_CMD_RD_BROAD 4
`define MESI_ISC_CBUS_CMD_NOP      0
`define MESI_ISC_CBUS_CMD_WR_SNOOP 1
`define MESI_ISC_CBUS_CMD_RD_SNOOP 2
`define MESI_ISC_CBUS_CMD_EN_WR    3
`define MESI_ISC_CBUS_CMD_EN_RD    4
`endif

module mesi_isc_cpu_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int SNOOP_LAT      = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  done_o,
  mesi_isc_cpu_agent_if.master  bus,
  output logic [CNT_WIDTH-1:0]  snoop_cnt_o,
  output logic                  err_o
);

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_BROAD   = 2'd1;
  localparam logic [1:0] R_WAIT_EN = 2'd2;
  localparam logic [1:0] R_ACCESS  = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP      = MBUS_CMD_WIDTH'(`MESI_ISC_MBUS_CMD_NOP);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(`MESI_ISC_MBUS_CMD_WR);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD       = MBUS_CMD_WIDTH'(`MESI_ISC_MBUS_CMD_RD);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(`MESI_ISC_MBUS_CMD_WR_BROAD);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(`MESI_ISC_MBUS_CMD_RD_BROAD);

  localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(`MESI_ISC_CBUS_CMD_WR_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(`MESI_ISC_CBUS_CMD_RD_SNOOP);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(`MESI_ISC_CBUS_CMD_EN_WR);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(`MESI_ISC_CBUS_CMD_EN_RD);

  localparam logic [3:0] LAT = 4'(SNOOP_LAT);

  // Request side state
  logic [1:0]                r_state_q, r_state_d;
  logic                      wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q, mbus_cmd_d;
  logic                      done_q, done_d;

  // Snoop side state
  logic [1:0]                s_state_q, s_state_d;
  logic [3:0]                dly_q, dly_d;
  logic                      is_snoop_q, is_snoop_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic                      err_q, err_d;

  // Command decode
  logic cmd_snoop, cmd_en_wr, cmd_en_rd, cmd_en, cmd_rsvd;
  logic en_accept;
  logic en_match;
  logic addr_ok;

  always_comb begin
    cmd_snoop = (bus.cbus_cmd_i == CB_WR_SNOOP) || (bus.cbus_cmd_i == CB_RD_SNOOP);
    cmd_en_wr = (bus.cbus_cmd_i == CB_EN_WR);
    cmd_en_rd = (bus.cbus_cmd_i == CB_EN_RD);
    cmd_en    = cmd_en_wr || cmd_en_rd;
    cmd_rsvd  = (bus.cbus_cmd_i > CB_EN_RD);
    // An EN is taken (and later acked) only when the responder is free; a
    // controller holds it until then, so every check keys off this cycle.
    en_accept = (s_state_q == S_IDLE) && cmd_en;
    en_match  = wr_q ? cmd_en_wr : cmd_en_rd;
  end

`ifdef MESI_ISC_AGENT_ADDR_CHK_EN
  assign addr_ok = (bus.cbus_addr_i == addr_q);
`else
  logic addr_unused;
  assign addr_unused = ^bus.cbus_addr_i;
  assign addr_ok     = 1'b1;
`endif

  // Request FSM: all main-bus outputs are registered, so each transition
  // also loads the command that appears on the following cycle.
  always_comb begin
    r_state_d  = r_state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    mbus_cmd_d = mbus_cmd_q;
    done_d     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (req_valid_i) begin
          wr_d       = req_wr_i;
          addr_d     = req_addr_i;
          mbus_cmd_d = req_wr_i ? MB_WR_BROAD : MB_RD_BROAD;
          r_state_d  = R_BROAD;
        end
      end
      R_BROAD: begin
        if (bus.mbus_ack_i) begin
          mbus_cmd_d = MB_NOP;
          r_state_d  = R_WAIT_EN;
        end
      end
      R_WAIT_EN: begin
        if (en_accept && en_match && addr_ok) begin
          mbus_cmd_d = wr_q ? MB_WR : MB_RD;
          r_state_d  = R_ACCESS;
        end
      end
      R_ACCESS: begin
        if (bus.mbus_ack_i) begin
          mbus_cmd_d = MB_NOP;
          done_d     = 1'b1;
          r_state_d  = R_IDLE;
        end
      end
      default: begin
        mbus_cmd_d = MB_NOP;
        r_state_d  = R_IDLE;
      end
    endcase
  end

  // Snoop FSM: runs independently of the request FSM.
  always_comb begin
    s_state_d  = s_state_q;
    dly_d      = dly_q;
    is_snoop_d = is_snoop_q;
    cnt_d      = cnt_q;
    case (s_state_q)
      S_IDLE: begin
        if (cmd_snoop) begin
          is_snoop_d = 1'b1;
          dly_d      = LAT;
          s_state_d  = (LAT == 4'd0) ? S_ACK : S_DELAY;
        end else if (cmd_en) begin
          is_snoop_d = 1'b0;
          s_state_d  = S_ACK;
        end
      end
      S_DELAY: begin
        dly_d = dly_q - 4'd1;
        if (dly_q == 4'd1) begin
          s_state_d = S_ACK;
        end
      end
      S_ACK: begin
        s_state_d = S_GAP;
        if (is_snoop_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // S_GAP: one dead cycle so a held command is not taken twice.
        s_state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (bus.mbus_ack_i && ((r_state_q == R_IDLE) || (r_state_q == R_WAIT_EN))) begin
      err_d = 1'b1;
    end
    if (en_accept && ((r_state_q != R_WAIT_EN) || !en_match)) begin
      err_d = 1'b1;
    end
    if (en_accept && (r_state_q == R_WAIT_EN) && en_match && !addr_ok) begin
      err_d = 1'b1;
    end
    if (cmd_rsvd) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q  <= R_IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      mbus_cmd_q <= MB_NOP;
      done_q     <= 1'b0;
      s_state_q  <= S_IDLE;
      dly_q      <= 4'd0;
      is_snoop_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      mbus_cmd_q <= mbus_cmd_d;
      done_q     <= done_d;
      s_state_q  <= s_state_d;
      dly_q      <= dly_d;
      is_snoop_q <= is_snoop_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign req_ready_o     = (r_state_q == R_IDLE);
  assign done_o          = done_q;
  assign bus.mbus_cmd_o  = mbus_cmd_q;
  assign bus.mbus_addr_o = addr_q;
  assign bus.cbus_ack_o  = (s_state_q == S_ACK);
  assign snoop_cnt_o     = cnt_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// tb/tb_mesi_isc_cpu_agent.sv - directed self-checking bench for mesi_isc_cpu_agent
module tb_mesi_isc_cpu_agent;

  localparam logic [2:0] CB_NOP      = 3'd0;
  localparam logic [2:0] CB_WR_SNOOP = 3'd1;
  localparam logic [2:0] CB_RD_SNOOP = 3'd2;
  localparam logic [2:0] CB_EN_WR    = 3'd3;
  localparam logic [2:0] CB_EN_RD    = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [31:0] req_addr;
  logic        req_ready, done, err;
  logic [15:0] snoop_cnt;
  logic        rdy0_unused, done0_unused, err0;
  logic        rdy5_unused, done5_unused, err5;
  logic [15:0] cnt0, cnt5;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mesi_isc_cpu_agent_if bus ();
  mesi_isc_cpu_agent_if bus0 ();
  mesi_isc_cpu_agent_if bus5 ();

  mesi_isc_cpu_agent #(.SNOOP_LAT(2)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_ready_o(req_ready), .done_o(done),
    .bus(bus), .snoop_cnt_o(snoop_cnt), .err_o(err)
  );

  mesi_isc_cpu_agent #(.SNOOP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid_i(1'b0), .req_wr_i(1'b0),
    .req_addr_i(32'h0), .req_ready_o(rdy0_unused), .done_o(done0_unused),
    .bus(bus0), .snoop_cnt_o(cnt0), .err_o(err0)
  );

  mesi_isc_cpu_agent #(.SNOOP_LAT(5)) dut5 (
    .clk(clk), .rst(rst), .req_valid_i(1'b0), .req_wr_i(1'b0),
    .req_addr_i(32'h0), .req_ready_o(rdy5_unused), .done_o(done5_unused),
    .bus(bus5), .snoop_cnt_o(cnt5), .err_o(err5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat [3];
    int acks [3];
    int a1, a2, nack, n, ndone;

    rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0;
    bus.mbus_ack_i = 1'b0;  bus.cbus_cmd_i = CB_NOP;  bus.cbus_addr_i = 32'h0;
    bus0.mbus_ack_i = 1'b0; bus0.cbus_cmd_i = CB_NOP; bus0.cbus_addr_i = 32'h0;
    bus5.mbus_ack_i = 1'b0; bus5.cbus_cmd_i = CB_NOP; bus5.cbus_addr_i = 32'h0;
    repeat (3) step();

    // Reset state
    chk("rst_mbus_cmd", bus.mbus_cmd_o, 0);
    chk("rst_mbus_addr", bus.mbus_addr_o, 0);
    chk("rst_cbus_ack", bus.cbus_ack_o, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", snoop_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b1;
    step();

    // Write flow
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h1; bus.cbus_addr_i = 32'h1;
    step(); req_valid = 1'b0;
    chk("wr_broad_cmd", bus.mbus_cmd_o, 3);
    chk("wr_broad_addr", bus.mbus_addr_o, 32'h1);
    chk("wr_busy", req_ready, 0);
    step();
    chk("wr_broad_hold", bus.mbus_cmd_o, 3);
    bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0;
    chk("wr_wait_cmd", bus.mbus_cmd_o, 0);
    chk("wr_wait_addr", bus.mbus_addr_o, 32'h1);
    step(); step();
    bus.cbus_cmd_i = CB_EN_WR;
    step();
    chk("wr_en_ack", bus.cbus_ack_o, 1);
    chk("wr_access_cmd", bus.mbus_cmd_o, 1);
    chk("wr_access_addr", bus.mbus_addr_o, 32'h1);
    bus.cbus_cmd_i = CB_NOP;
    step();
    chk("wr_en_ack_pulse", bus.cbus_ack_o, 0);
    chk("wr_access_hold", bus.mbus_cmd_o, 1);
    bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0;
    chk("wr_done", done, 1);
    chk("wr_end_cmd", bus.mbus_cmd_o, 0);
    chk("wr_end_ready", req_ready, 1);
    step();
    chk("wr_done_pulse", done, 0);
    chk("wr_err", err, 0);
    chk("wr_cnt", snoop_cnt, 0);

    // Snoop latency sweep: index 0 -> LAT0, 1 -> LAT2, 2 -> LAT5
    for (int i = 0; i < 3; i++) begin
      lat[i] = -1;
      acks[i] = 0;
    end
    bus0.cbus_cmd_i = CB_WR_SNOOP;
    bus.cbus_cmd_i  = CB_WR_SNOOP;
    bus5.cbus_cmd_i = CB_WR_SNOOP;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (bus0.cbus_ack_o === 1'b1) begin
        acks[0]++; if (lat[0] < 0) lat[0] = k; bus0.cbus_cmd_i = CB_NOP;
      end
      if (bus.cbus_ack_o === 1'b1) begin
        acks[1]++; if (lat[1] < 0) lat[1] = k; bus.cbus_cmd_i = CB_NOP;
      end
      if (bus5.cbus_ack_o === 1'b1) begin
        acks[2]++; if (lat[2] < 0) lat[2] = k; bus5.cbus_cmd_i = CB_NOP;
      end
    end
    chk("lat0_cycle", lat[0], 1);
    chk("lat2_cycle", lat[1], 3);
    chk("lat5_cycle", lat[2], 6);
    chk("lat0_pulses", acks[0], 1);
    chk("lat2_pulses", acks[1], 1);
    chk("lat5_pulses", acks[2], 1);
    chk("lat0_cnt", cnt0, 1);
    chk("lat2_cnt", snoop_cnt, 1);
    chk("lat5_cnt", cnt5, 1);
    chk("lat0_err", err0, 0);
    chk("lat5_err", err5, 0);

    // Back-to-back RD_SNOOP, command held across both
    a1 = 0; a2 = 0; nack = 0;
    bus.cbus_cmd_i = CB_RD_SNOOP;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (bus.cbus_ack_o === 1'b1) begin
        nack++;
        if (nack == 1) a1 = k;
        else begin
          a2 = k;
          bus.cbus_cmd_i = CB_NOP;
        end
      end
    end
    chk("b2b_first", a1, 3);
    chk("b2b_second", a2, 8);
    chk("b2b_acks", nack, 2);
    chk("b2b_cnt", snoop_cnt, 3);

    // Snoop overlapping a read broadcast
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h40; bus.cbus_addr_i = 32'h40;
    step(); req_valid = 1'b0;
    chk("ov_broad_cmd", bus.mbus_cmd_o, 4);
    chk("ov_broad_addr", bus.mbus_addr_o, 32'h40);
    bus.cbus_cmd_i = CB_RD_SNOOP;
    step();
    chk("ov_broad_hold", bus.mbus_cmd_o, 4);
    chk("ov_ack_early1", bus.cbus_ack_o, 0);
    step();
    chk("ov_ack_early2", bus.cbus_ack_o, 0);
    step();
    chk("ov_snoop_ack", bus.cbus_ack_o, 1);
    chk("ov_broad_still", bus.mbus_cmd_o, 4);
    bus.cbus_cmd_i = CB_NOP; bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0;
    chk("ov_wait_cmd", bus.mbus_cmd_o, 0);
    bus.cbus_cmd_i = CB_EN_RD;
    n = 0;
    while (bus.cbus_ack_o !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    chk("ov_en_ack", bus.cbus_ack_o, 1);
    chk("ov_en_wait", n, 2);
    chk("ov_rd_cmd", bus.mbus_cmd_o, 2);
    chk("ov_rd_addr", bus.mbus_addr_o, 32'h40);
    bus.cbus_cmd_i = CB_NOP; bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0;
    chk("ov_done", done, 1);
    chk("ov_end_cmd", bus.mbus_cmd_o, 0);
    step();
    chk("ov_done_pulse", done, 0);
    chk("ov_cnt", snoop_cnt, 4);
    chk("ov_err", err, 0);

    // Errors: unexpected EN_RD, then reserved command
    bus.cbus_cmd_i = CB_EN_RD;
    step();
    chk("err_en_acked", bus.cbus_ack_o, 1);
    chk("err_en_flag", err, 1);
    chk("err_en_ready", req_ready, 1);
    chk("err_en_cmd", bus.mbus_cmd_o, 0);
    bus.cbus_cmd_i = CB_NOP;
    step();
    bus.cbus_cmd_i = 3'd6;
    nack = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.cbus_ack_o === 1'b1) nack++;
    end
    chk("err_rsvd_noack", nack, 0);
    chk("err_sticky", err, 1);
    chk("err_cnt", snoop_cnt, 4);
    bus.cbus_cmd_i = CB_NOP;

    // Reset during R_ACCESS
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h8; bus.cbus_addr_i = 32'h8;
    step(); req_valid = 1'b0; bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0; bus.cbus_cmd_i = CB_EN_WR;
    step();
    chk("mid_access_cmd", bus.mbus_cmd_o, 1);
    bus.cbus_cmd_i = CB_NOP;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cmd", bus.mbus_cmd_o, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cnt", snoop_cnt, 0);
    step(); step();
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("mid_ready", req_ready, 1);
    chk("mid_no_done", ndone, 0);
    chk("mid_idle_cmd", bus.mbus_cmd_o, 0);

    // EN_WR with cbus address differing from the request address
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h1; bus.cbus_addr_i = 32'h2;
    step(); req_valid = 1'b0; bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0; bus.cbus_cmd_i = CB_EN_WR;
    step(); bus.cbus_cmd_i = CB_NOP;
    chk("achk_en_acked", bus.cbus_ack_o, 1);
`ifdef MESI_ISC_AGENT_ADDR_CHK_EN
    chk("achk_err", err, 1);
    chk("achk_stay_cmd", bus.mbus_cmd_o, 0);
    chk("achk_stay_busy", req_ready, 0);
    step(); step();
    bus.cbus_addr_i = 32'h1; bus.cbus_cmd_i = CB_EN_WR;
    step(); bus.cbus_cmd_i = CB_NOP;
    chk("achk_retry_cmd", bus.mbus_cmd_o, 1);
`else
    chk("achk_off_err", err, 0);
    chk("achk_off_cmd", bus.mbus_cmd_o, 1);
`endif
    step(); bus.mbus_ack_i = 1'b1;
    step(); bus.mbus_ack_i = 1'b0;
    chk("achk_done", done, 1);
    chk("achk_ready", req_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
